lsu_spu_ldst_rcv: RTL and testbench

LSU-side receiver for SPU load/store requests on their way to the PCX. It captures the 123-bit SPU ld/st packet into a small FIFO and decodes the target bank from the address. It then runs a request/grant handshake with the PCX arbiter, drives the granted packet with its valid bit set, and reports each issued request back to the SPU. It is the consuming end of the SPU-to-LSU packet path.

---
 rtl/lsu_spu_ldst_rcv_pkg.sv | 38 +++
 rtl/lsu_spu_ldst_rcv_if.sv | 26 ++
 rtl/lsu_spu_ldst_rcv_fifo.sv | 46 ++++
 rtl/lsu_spu_ldst_rcv.sv | 91 +++++++++
 tb/tb_lsu_spu_ldst_rcv.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/lsu_spu_ldst_rcv_pkg.sv
// Shared definitions for the SPU ld/st receiver.
// Package lsu_spu_pkg: packet field offsets, widths, FSM states, FIFO entry
// layout and the bank decode helpers.
package lsu_spu_pkg;
  localparam int PCKT_W     = 123;
  localparam int NBANK      = 5;
  localparam int RQ_HI      = 122;
  localparam int RQ_LO      = 118;
  localparam int TID_HI     = 113;
  localparam int TID_LO     = 112;
  localparam int ADDR_HI    = 103;
  localparam int ADDR_LO    = 64;
  localparam int ADDR39_BIT = 103;
  localparam int BANK_HI    = 71;
  localparam int BANK_LO    = 70;

  typedef enum logic [1:0] {IDLE, REQ, SEND} state_e;

  // FIFO entry: encoded bank (0..4) kept next to the packet so the request
  // path never has to re-decode the address.
  typedef struct packed {
    logic [2:0]        bank;
    logic [PCKT_W-1:0] pckt;
  } ent_t;

  // addr[39] selects IO (bank 4); otherwise addr[7:6] picks an L2 bank.
  function automatic logic [2:0] bank_idx(input logic [PCKT_W-1:0] p);
    return p[ADDR39_BIT] ? 3'd4 : {1'b0, p[BANK_HI:BANK_LO]};
  endfunction

  function automatic logic [NBANK-1:0] bank_oh(input logic [2:0] idx);
    return 5'b00001 << idx;
  endfunction

  function automatic logic [NBANK-1:0] bank_decode(input logic [PCKT_W-1:0] p);
    return bank_oh(bank_idx(p));
  endfunction
endpackage

// File: rtl/lsu_spu_ldst_rcv_if.sv
// SPU->LSU packet path and LSU->PCX request/grant bus.
// master: environment side (SPU and PCX arbiter) driving packet and grant.
// slave : the receiver, driving request, data and SPU status.
interface lsu_spu_ldst_rcv_if;
  import lsu_spu_pkg::*;
  logic [PCKT_W-1:0] spu_lsu_ldst_pckt;
  logic              spu_lsu_ldst_pckt_vld;
  logic [NBANK-1:0]  pcx_spu_grant_px;
  logic [NBANK-1:0]  spu_pcx_req_pq;
  logic [PCKT_W:0]   spu_pcx_data_px;
  logic              lsu_spu_pckt_full;
  logic              lsu_spu_pckt_sent_vld;
  logic [1:0]        lsu_spu_pckt_sent_tid;
  logic              lsu_spu_ovfl_err;

  modport master (
    output spu_lsu_ldst_pckt, spu_lsu_ldst_pckt_vld, pcx_spu_grant_px,
    input  spu_pcx_req_pq, spu_pcx_data_px, lsu_spu_pckt_full,
           lsu_spu_pckt_sent_vld, lsu_spu_pckt_sent_tid, lsu_spu_ovfl_err
  );
  modport slave (
    input  spu_lsu_ldst_pckt, spu_lsu_ldst_pckt_vld, pcx_spu_grant_px,
    output spu_pcx_req_pq, spu_pcx_data_px, lsu_spu_pckt_full,
           lsu_spu_pckt_sent_vld, lsu_spu_pckt_sent_tid, lsu_spu_ovfl_err
  );
endinterface

// File: rtl/lsu_spu_ldst_rcv_fifo.sv
// lsu_spu_rcv_fifo: DEPTH-entry FIFO of ent_t (packet + bank).
// Ports: clk_i, rst_n_i (async low), push_i/wdata_i (accepted push),
// pop_i, rdata_o (head), full_o, empty_o, count_o.
// Pointers and count reset; entry storage does not.
module lsu_spu_rcv_fifo import lsu_spu_pkg::*; #(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          push_i,
  input  ent_t          wdata_i,
  input  logic          pop_i,
  output ent_t          rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  ent_t          mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  assign cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wp_q <= wp_q + AW'(1);
      if (pop_i)  rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i)
    if (push_i) mem_q[wp_q] <= wdata_i;

  assign rdata_o = mem_q[rp_q];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
endmodule

// File: rtl/lsu_spu_ldst_rcv.sv
// lsu_spu_ldst_rcv: buffers SPU ld/st packets and issues them to the PCX
// with a per-bank request/grant handshake.
// Ports: rclk, reset_l (async low), bus (lsu_spu_ldst_rcv_if.slave).
// Optional macro LSU_SPU_RCV_BYPASS_EN: when idle and empty, a push drives
// the request combinationally from the incoming packet in the push cycle.
module lsu_spu_ldst_rcv import lsu_spu_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic                rclk,
  input  logic                reset_l,
  lsu_spu_ldst_rcv_if.slave   bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_e           state_q, state_d;
  ent_t             head;
  logic             full, empty, pop, push_ok, hit;
  logic [CW-1:0]    cnt;
  logic [NBANK-1:0] req;
  logic [PCKT_W:0]  data_q;
  logic             sent_vld_q, ovfl_q;
  logic [1:0]       tid_q;

  assign pop     = (state_q == SEND);
  // The SEND-cycle pop frees a slot, so a push into a full FIFO is taken then.
  assign push_ok = bus.spu_lsu_ldst_pckt_vld && (!full || pop);
  // Grants are only honoured in REQ and only on the requested bank.
  assign hit     = (state_q == REQ) && |(bus.pcx_spu_grant_px & bank_oh(head.bank));

  lsu_spu_rcv_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (rclk),
    .rst_n_i (reset_l),
    .push_i  (push_ok),
    .wdata_i ('{bank: bank_idx(bus.spu_lsu_ldst_pckt), pckt: bus.spu_lsu_ldst_pckt}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (cnt)
  );

  always_ff @(posedge rclk or negedge reset_l)
    if (!reset_l) state_q <= IDLE;
    else          state_q <= state_d;

  always_comb begin
    state_d = state_q;
    req     = '0;
    case (state_q)
      IDLE: begin
        if (!empty || push_ok) state_d = REQ;
`ifdef LSU_SPU_RCV_BYPASS_EN
        if (empty && bus.spu_lsu_ldst_pckt_vld)
          req = bank_decode(bus.spu_lsu_ldst_pckt);
`endif
      end
      REQ: begin
        req = bank_oh(head.bank);
        if (hit) state_d = SEND;
      end
      SEND:    state_d = (cnt > CW'(1) || push_ok) ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Data is captured at the grant edge so it is valid during SEND; the
  // payload bits hold their last value afterwards.
  always_ff @(posedge rclk or negedge reset_l) begin
    if (!reset_l) begin
      data_q     <= '0;
      sent_vld_q <= 1'b0;
      tid_q      <= '0;
      ovfl_q     <= 1'b0;
    end else begin
      data_q[PCKT_W] <= hit;
      sent_vld_q     <= hit;
      if (hit) begin
        data_q[PCKT_W-1:0] <= head.pckt;
        tid_q              <= head.pckt[TID_HI:TID_LO];
      end
      if (bus.spu_lsu_ldst_pckt_vld && !push_ok) ovfl_q <= 1'b1;
    end
  end

  assign bus.spu_pcx_req_pq        = req;
  assign bus.spu_pcx_data_px       = data_q;
  assign bus.lsu_spu_pckt_full     = full;
  assign bus.lsu_spu_pckt_sent_vld = sent_vld_q;
  assign bus.lsu_spu_pckt_sent_tid = tid_q;
  assign bus.lsu_spu_ovfl_err      = ovfl_q;
endmodule

// File: tb/tb_lsu_spu_ldst_rcv.sv
// Testbench for lsu_spu_ldst_rcv (DEPTH=2). Expected packets are queued when
// pushed and compared against each sent pulse.
module tb_lsu_spu_ldst_rcv;
  import lsu_spu_pkg::*;
  localparam int DEPTH = 2;

  logic rclk = 1'b0;
  logic reset_l = 1'b0;
  always #5 rclk = ~rclk;

  lsu_spu_ldst_rcv_if bus();

  lsu_spu_ldst_rcv #(.DEPTH(DEPTH)) dut (
    .rclk    (rclk),
    .reset_l (reset_l),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [PCKT_W-1:0] sb[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PCKT_W-1:0] mk(input logic [1:0] tid, input logic [39:0] addr,
                                           input logic [63:0] d);
    logic [PCKT_W-1:0] p;
    p = '0;
    p[RQ_HI:RQ_LO]     = 5'h10;
    p[TID_HI:TID_LO]   = tid;
    p[ADDR_HI:ADDR_LO] = addr;
    p[63:0]            = d;
    return p;
  endfunction

  // Scoreboard: every sent pulse must match the oldest accepted packet.
  always @(negedge rclk) begin
    if (reset_l && bus.lsu_spu_pckt_sent_vld) begin
      if (sb.size() == 0) chk("unexp_sent", 1, 0);
      else begin
        logic [PCKT_W-1:0] e;
        e = sb.pop_front();
        chk("sb_data", bus.spu_pcx_data_px, {1'b1, e});
        chk("sb_tid", bus.lsu_spu_pckt_sent_tid, e[TID_HI:TID_LO]);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge rclk); #1; end
  endtask

  task automatic push(input logic [PCKT_W-1:0] p, input bit acc);
    bus.spu_lsu_ldst_pckt = p;
    bus.spu_lsu_ldst_pckt_vld = 1'b1;
    if (acc) sb.push_back(p);
    cyc();
    bus.spu_lsu_ldst_pckt_vld = 1'b0;
  endtask

  // Wait (bounded) for a request, grant it for one cycle; returns in SEND.
  task automatic grant_req();
    int t;
    t = 0;
    while (bus.spu_pcx_req_pq == '0 && t < 20) begin cyc(); t++; end
    chk("req_wait", t < 20, 1);
    bus.pcx_spu_grant_px = bus.spu_pcx_req_pq;
    cyc();
    bus.pcx_spu_grant_px = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"},  bus.spu_pcx_req_pq, 0);
    chk({tag, "_data"}, bus.spu_pcx_data_px, 0);
    chk({tag, "_full"}, bus.lsu_spu_pckt_full, 0);
    chk({tag, "_svld"}, bus.lsu_spu_pckt_sent_vld, 0);
    chk({tag, "_stid"}, bus.lsu_spu_pckt_sent_tid, 0);
    chk({tag, "_ovfl"}, bus.lsu_spu_ovfl_err, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [PCKT_W-1:0] p, pa, pb, pc;
    bus.spu_lsu_ldst_pckt = '0;
    bus.spu_lsu_ldst_pckt_vld = 1'b0;
    bus.pcx_spu_grant_px = '0;
    #12;
    chk_zero("rst");
    cyc(2);
    reset_l = 1'b1;
    cyc();

    // T1: bank 1, tid 2; req in N+1, grant in N+3, issue in N+4.
    p = mk(2'd2, 40'h00_0000_0040, 64'hA1A1_0000_1111_2222);
    push(p, 1);
    @(negedge rclk) chk("t1_req", bus.spu_pcx_req_pq, 5'b00010);
    cyc(2);
    bus.pcx_spu_grant_px = 5'b00010;
    cyc();
    bus.pcx_spu_grant_px = '0;
    @(negedge rclk);
    chk("t1_svld", bus.lsu_spu_pckt_sent_vld, 1);
    chk("t1_vbit", bus.spu_pcx_data_px[PCKT_W], 1);
    chk("t1_tid", bus.lsu_spu_pckt_sent_tid, 2);
    chk("t1_req0", bus.spu_pcx_req_pq, 0);
    cyc();
    @(negedge rclk);
    chk("t1_idle_req", bus.spu_pcx_req_pq, 0);
    chk("t1_vbit0", bus.spu_pcx_data_px[PCKT_W], 0);
    chk("t1_hold", bus.spu_pcx_data_px[PCKT_W-1:0], p);

    // T2: IO bank wins over addr[7:6]=3; wrong-bank grant ignored.
    p = mk(2'd1, 40'h80_0000_00C0, 64'hB2B2_3333_4444_5555);
    push(p, 1);
    @(negedge rclk) chk("t2_req", bus.spu_pcx_req_pq, 5'b10000);
    cyc();
    bus.pcx_spu_grant_px = 5'b01000;
    cyc();
    bus.pcx_spu_grant_px = '0;
    @(negedge rclk);
    chk("t2_ign_svld", bus.lsu_spu_pckt_sent_vld, 0);
    chk("t2_ign_req", bus.spu_pcx_req_pq, 5'b10000);
    grant_req();
    @(negedge rclk) chk("t2_svld", bus.lsu_spu_pckt_sent_vld, 1);
    cyc();

    // T4: push into a full FIFO during SEND is accepted.
    pa = mk(2'd0, 40'h00_0000_0000, 64'h0000_0000_0000_00AA);
    pb = mk(2'd1, 40'h00_0000_0040, 64'h0000_0000_0000_00BB);
    pc = mk(2'd3, 40'h00_0000_0080, 64'h0000_0000_0000_00CC);
    push(pa, 1);
    push(pb, 1);
    @(negedge rclk) chk("t4_full", bus.lsu_spu_pckt_full, 1);
    grant_req();
    push(pc, 1);
    @(negedge rclk);
    chk("t4_full2", bus.lsu_spu_pckt_full, 1);
    chk("t4_ovfl", bus.lsu_spu_ovfl_err, 0);
    grant_req();
    grant_req();
    cyc(2);
    chk("t4_full0", bus.lsu_spu_pckt_full, 0);
    chk("t4_drain", sb.size(), 0);

    // T3: third push while full is dropped and sets the sticky error.
    pa = mk(2'd3, 40'h00_0000_00C0, 64'hD0D0_0000_0000_0001);
    pb = mk(2'd2, 40'h00_0000_0000, 64'hD0D0_0000_0000_0002);
    pc = mk(2'd1, 40'h00_0000_0040, 64'hD0D0_0000_0000_0003);
    push(pa, 1);
    push(pb, 1);
    @(negedge rclk);
    chk("t3_full", bus.lsu_spu_pckt_full, 1);
    chk("t3_ovfl0", bus.lsu_spu_ovfl_err, 0);
    push(pc, 0);
    @(negedge rclk);
    chk("t3_ovfl1", bus.lsu_spu_ovfl_err, 1);
    chk("t3_full2", bus.lsu_spu_pckt_full, 1);
    grant_req();
    grant_req();
    cyc(2);
    chk("t3_drain", sb.size(), 0);
    chk("t3_full0", bus.lsu_spu_pckt_full, 0);
    chk("t3_sticky", bus.lsu_spu_ovfl_err, 1);

    // T5: async reset in REQ with two entries.
    push(mk(2'd1, 40'h00_0000_0040, 64'h5), 1);
    push(mk(2'd2, 40'h00_0000_0080, 64'h6), 1);
    #2;
    reset_l = 1'b0;
    #1;
    chk_zero("t5");
    sb.delete();
    cyc();
    reset_l = 1'b1;
    repeat (3) begin
      cyc();
      @(negedge rclk) chk("t5_noreq", bus.spu_pcx_req_pq, 0);
    end
    push(mk(2'd3, 40'h00_0000_00C0, 64'h7), 1);
    grant_req();
    cyc(2);
    chk("t5_drain", sb.size(), 0);

    // T6: same-cycle request only with the bypass build.
    p = mk(2'd0, 40'h00_0000_0080, 64'hE6E6_0000_0000_0006);
    bus.spu_lsu_ldst_pckt = p;
    bus.spu_lsu_ldst_pckt_vld = 1'b1;
    sb.push_back(p);
`ifdef LSU_SPU_RCV_BYPASS_EN
    @(negedge rclk) chk("t6_byp_req", bus.spu_pcx_req_pq, 5'b00100);
`else
    @(negedge rclk) chk("t6_nobyp_req", bus.spu_pcx_req_pq, 5'b00000);
`endif
    cyc();
    bus.spu_lsu_ldst_pckt_vld = 1'b0;
    @(negedge rclk) chk("t6_req", bus.spu_pcx_req_pq, 5'b00100);
    grant_req();
    cyc(2);

    chk("final_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
